// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
// Optional feature macro: PISO_PARITY_EN (appends one even-parity bit per frame).
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter must hold 0..WIDTH so it can never wrap inside a frame.
  localparam int CNT_W = $clog2(DEFAULT_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on load, advances on enable, saturates at the last data bit.
// The last flag marks the cycle that carries data bit WIDTH-1.
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = piso_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  logic [CW-1:0] cnt;

  // Count data bits of the frame in flight; a new accept restarts at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(WIDTH - 1))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input and frame-start strobe.
// Words may be accepted on the last frame bit so consecutive frames have no gap.
// Optional feature macro: PISO_PARITY_EN (adds an even-parity cycle after the data bits).
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  import piso_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             last;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   ((state == SHIFT) && !accept),
    .last (last)
  );

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and ready: ready only when the current cycle is the frame's final bit or idle.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
      end
      SHIFT: begin
        if (last) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          din_ready  = 1'b1;
          state_next = IDLE;
`endif
        end
      end
      PARITY: begin
        din_ready  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      din_ready = 1'b0;
    end
    accept = din_valid && din_ready;
    if (accept) begin
      state_next = SHIFT;
    end
  end

  // Shift register and registered serial outputs; bit 0 is driven straight from din on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef PISO_PARITY_EN
      par         <= 1'b0;
`endif
    end else if (accept) begin
      shreg       <= din;
      sout        <= MSB_FIRST ? din[WIDTH-1] : din[0];
      sout_valid  <= 1'b1;
      frame_start <= 1'b1;
`ifdef PISO_PARITY_EN
      par         <= ^din;
`endif
    end else if ((state == SHIFT) && !last) begin
      if (MSB_FIRST) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        sout  <= shreg[WIDTH-2];
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
        sout  <= shreg[1];
      end
      sout_valid  <= 1'b1;
      frame_start <= 1'b0;
`ifdef PISO_PARITY_EN
    end else if (state == SHIFT) begin
      sout        <= par;
      sout_valid  <= 1'b1;
      frame_start <= 1'b0;
`endif
    end else begin
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one MSB-first and one LSB-first instance share stimulus.
// Expected bits come from a frame queue model; honours PISO_PARITY_EN if defined.
module tb_piso_serializer;

  localparam int W = 4;

  typedef struct packed {
    logic sout;
    logic valid;
    logic fs;
  } obit_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         so_m;
    logic         so_l;
    logic         vld;
    logic         fs;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         ready_m, sout_m, valid_m, fs_m, busy_m;
  logic         ready_l, sout_l, valid_l, fs_l, busy_l;

  int errors = 0;
  int checks = 0;

  obit_t pend_m[$];
  obit_t pend_l[$];
  obit_t cur_m;
  obit_t cur_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (ready_m),
    .sout        (sout_m),
    .sout_valid  (valid_m),
    .frame_start (fs_m),
    .busy        (busy_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (ready_l),
    .sout        (sout_l),
    .sout_valid  (valid_l),
    .frame_start (fs_l),
    .busy        (busy_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Reference model: each accepted word becomes a list of output cycles for each bit order.
  task automatic pushFrame(input logic [W-1:0] d);
    for (int k = 0; k < W; k++) begin
      pend_m.push_back('{sout: d[W-1-k], valid: 1'b1, fs: (k == 0)});
      pend_l.push_back('{sout: d[k], valid: 1'b1, fs: (k == 0)});
    end
`ifdef PISO_PARITY_EN
    pend_m.push_back('{sout: ^d, valid: 1'b1, fs: 1'b0});
    pend_l.push_back('{sout: ^d, valid: 1'b1, fs: 1'b0});
`endif
  endtask

  task automatic modelReset();
    pend_m.delete();
    pend_l.delete();
    cur_m = '0;
    cur_l = '0;
  endtask

  task automatic checkOutput();
    chk("sout_msb", sout_m, cur_m.sout);
    chk("valid_msb", valid_m, cur_m.valid);
    chk("fs_msb", fs_m, cur_m.fs);
    chk("busy_msb", busy_m, cur_m.valid);
    chk("sout_lsb", sout_l, cur_l.sout);
    chk("valid_lsb", valid_l, cur_l.valid);
    chk("fs_lsb", fs_l, cur_l.fs);
    chk("busy_lsb", busy_l, cur_l.valid);
  endtask

  // One clock of stimulus: drive, check ready against the model, advance the model, check outputs.
  task automatic applyStimulus(input logic v, input logic [W-1:0] d, output logic rdy_seen);
    logic exp_ready;
    logic acc;
    din_valid = v;
    din       = d;
    #1;
    exp_ready = (pend_m.size() == 0) && !rst;
    rdy_seen  = ready_m;
    chk("ready_msb", ready_m, exp_ready);
    chk("ready_lsb", ready_l, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    if (acc) pushFrame(d);
    cur_m = (pend_m.size() != 0) ? pend_m.pop_front() : '0;
    cur_l = (pend_l.size() != 0) ? pend_l.pop_front() : '0;
    @(negedge clk);
    checkOutput();
  endtask

  // Asynchronous reset pulse from mid-cycle; outputs must drop without waiting for a clock edge.
  task automatic pulseReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    chk("ready_in_rst", ready_m, 1'b0);
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
  endtask

  vec_t tbl[10];
  logic rdy;

  initial begin
    // Back-to-back 1101 then 1000; second word held valid from cycle 1 (ignored until last bit).
    tbl[0] = '{1'b1, 4'b1101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    modelReset();
    #100;
    checkOutput();
    chk("ready_in_rst", ready_m, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready_m, 1'b1);

`ifndef PISO_PARITY_EN
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].v, tbl[i].d, rdy);
      chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].r);
      chk($sformatf("tbl%0d_sout_msb", i), sout_m, tbl[i].so_m);
      chk($sformatf("tbl%0d_sout_lsb", i), sout_l, tbl[i].so_l);
      chk($sformatf("tbl%0d_valid", i), valid_m, tbl[i].vld);
      chk($sformatf("tbl%0d_fs", i), fs_m, tbl[i].fs);
    end
`else
    begin
      logic [4:0] exp_m;
      logic [4:0] exp_l;
      exp_m = 5'b11011;
      exp_l = 5'b10111;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(i == 0, 4'b1101, rdy);
        if (i < 5) begin
          chk($sformatf("par%0d_sout_msb", i), sout_m, exp_m[4-i]);
          chk($sformatf("par%0d_sout_lsb", i), sout_l, exp_l[4-i]);
          chk($sformatf("par%0d_valid", i), valid_m, 1'b1);
        end else begin
          chk("par_end_valid", valid_m, 1'b0);
        end
      end
    end
`endif

    // Word changes to 0000 while busy; the frame in flight must remain 1101.
    applyStimulus(1'b1, 4'b1101, rdy);
    for (int i = 0; i < W + 2; i++) applyStimulus(1'b1, 4'b0000, rdy);
    for (int i = 0; i < W + 2; i++) applyStimulus(1'b0, 4'b0000, rdy);

    // Reset after the second bit of 1101, then a clean 1000 frame.
    applyStimulus(1'b1, 4'b1101, rdy);
    applyStimulus(1'b0, 4'b1101, rdy);
    pulseReset();
    applyStimulus(1'b1, 4'b1000, rdy);
    for (int i = 0; i < W + 2; i++) applyStimulus(1'b0, 4'b0000, rdy);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulseReset();
      end else begin
        applyStimulus($urandom_range(0, 9) < 6, W'($urandom), rdy);
      end
    end
    for (int i = 0; i < W + 3; i++) applyStimulus(1'b0, 4'b0000, rdy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
